// File: rtl/simd_fetch_pkg.sv
// Shared types and constants for the bilinear SIMD operand fetch block.
package simd_fetch_pkg;

    localparam int PIX_W      = 8;
    localparam int INT_W      = 8;
    localparam int FRAC_W_DEF = 8;
    localparam int DIM_W      = 9;
    localparam int CORNERS    = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, LOAD} state_t;
    typedef enum logic [1:0] {C00, C10, C01, C11} corner_t;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [INT_W-1:0] coord_int_t;
    typedef pix_t [CORNERS-1:0] quad_t;

    function automatic int coord_w(input int frac_w);
        return INT_W + frac_w;
    endfunction

endpackage

// File: rtl/simd_addr_gen.sv
// Neighbour-pixel address generator: (x0, y0, corner) -> row-major byte address.
// Optional edge replication when SIMD_FETCH_CLAMP_EN is defined.
module simd_addr_gen
    import simd_fetch_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [INT_W-1:0]  x0_i,
    input  logic [INT_W-1:0]  y0_i,
    input  corner_t           corner_i,
    input  logic [DIM_W-1:0]  img_w_i,
    input  logic [DIM_W-1:0]  img_h_i,
    output logic [ADDR_W-1:0] addr_o
);

    localparam int FULL_W = (ADDR_W > 2*DIM_W+1) ? ADDR_W : 2*DIM_W+1;

    logic [DIM_W-1:0]  x_raw;
    logic [DIM_W-1:0]  y_raw;
    logic [DIM_W-1:0]  x_sel;
    logic [DIM_W-1:0]  y_sel;
    logic [FULL_W-1:0] full;

    // x0+1 / y0+1 can reach 256, hence the extra bit before clamping
    assign x_raw = {1'b0, x0_i} + DIM_W'((corner_i == C10) || (corner_i == C11));
    assign y_raw = {1'b0, y0_i} + DIM_W'((corner_i == C01) || (corner_i == C11));

`ifdef SIMD_FETCH_CLAMP_EN
    assign x_sel = (x_raw >= img_w_i) ? img_w_i - 1'b1 : x_raw;
    assign y_sel = (y_raw >= img_h_i) ? img_h_i - 1'b1 : y_raw;
`else
    logic unused_img_h;
    assign unused_img_h = ^img_h_i;
    assign x_sel = x_raw;
    assign y_sel = y_raw;
`endif

    assign full   = FULL_W'(y_sel) * FULL_W'(img_w_i) + FULL_W'(x_sel);
    assign addr_o = full[ADDR_W-1:0];

endmodule

// File: rtl/simd_operand_fetch.sv
// Bilinear operand fetch: reads 4 neighbours per lane, lane-major, then strobes a full operand vector.
// Build option SIMD_FETCH_CLAMP_EN enables edge-replicating coordinate clamping in simd_addr_gen.
module simd_operand_fetch
    import simd_fetch_pkg::*;
#(
    parameter int N      = 4,
    parameter int ADDR_W = 16,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DIM_W-1:0]                img_w,
    input  logic [DIM_W-1:0]                img_h,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [N-1:0][INT_W+FRAC_W-1:0]  req_x,
    input  logic [N-1:0][INT_W+FRAC_W-1:0]  req_y,
    output logic                            mem_rd,
    output logic [ADDR_W-1:0]               mem_addr,
    input  logic [PIX_W-1:0]                mem_data,
    input  logic                            simd_ready,
    output logic                            load,
    output logic [N-1:0][PIX_W-1:0]         I00_out,
    output logic [N-1:0][PIX_W-1:0]         I10_out,
    output logic [N-1:0][PIX_W-1:0]         I01_out,
    output logic [N-1:0][PIX_W-1:0]         I11_out,
    output logic [N-1:0][FRAC_W-1:0]        alpha_out,
    output logic [N-1:0][FRAC_W-1:0]        beta_out,
    output logic                            busy
);

    localparam int NREQ   = CORNERS * N;
    localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W  = LANE_W + 2;
    localparam int CW     = coord_w(FRAC_W);

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [IDX_W-1:0]  ridx_q;
    logic              rd_q;
    logic              last_issue;
    logic              accept;
    logic [LANE_W-1:0] lane_sel;
    logic [ADDR_W-1:0] gen_addr;

    logic [INT_W-1:0]  x0_q    [N];
    logic [INT_W-1:0]  y0_q    [N];
    logic [FRAC_W-1:0] alpha_q [N];
    logic [FRAC_W-1:0] beta_q  [N];
    logic [PIX_W-1:0]  pix_q   [N][CORNERS];

    assign last_issue = (idx_q == IDX_W'(NREQ-1));
    assign accept     = (state_q == IDLE) && req_valid;
    assign lane_sel   = idx_q[IDX_W-1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid)  state_d = ISSUE;
            ISSUE:   if (last_issue) state_d = DRAIN;
            DRAIN:                   state_d = LOAD;
            LOAD:    if (simd_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        mem_rd    = 1'b0;
        load      = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ISSUE:   mem_rd = 1'b1;
            LOAD:    load   = simd_ready;
            default: ;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (state_q == ISSUE) begin
            idx_d = last_issue ? '0 : idx_q + 1'b1;
        end
    end

    // rd_q/ridx_q follow the 1-cycle memory latency so data lands in the right register
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            rd_q   <= 1'b0;
            ridx_q <= '0;
        end else begin
            idx_q  <= idx_d;
            rd_q   <= mem_rd;
            ridx_q <= idx_q;
        end
    end

    simd_addr_gen #(
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .x0_i     (x0_q[lane_sel]),
        .y0_i     (y0_q[lane_sel]),
        .corner_i (corner_t'(idx_q[1:0])),
        .img_w_i  (img_w),
        .img_h_i  (img_h),
        .addr_o   (gen_addr)
    );

    assign mem_addr = mem_rd ? gen_addr : '0;

    genvar gi, gc;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    x0_q[gi]    <= '0;
                    y0_q[gi]    <= '0;
                    alpha_q[gi] <= '0;
                    beta_q[gi]  <= '0;
                end else if (accept) begin
                    x0_q[gi]    <= req_x[gi][CW-1:FRAC_W];
                    y0_q[gi]    <= req_y[gi][CW-1:FRAC_W];
                    alpha_q[gi] <= req_x[gi][FRAC_W-1:0];
                    beta_q[gi]  <= req_y[gi][FRAC_W-1:0];
                end
            end

            for (gc = 0; gc < CORNERS; gc++) begin : g_corner
                always_ff @(posedge clk) begin
                    if (rst) begin
                        pix_q[gi][gc] <= '0;
                    end else if (rd_q && (ridx_q == IDX_W'(gi*CORNERS + gc))) begin
                        pix_q[gi][gc] <= mem_data;
                    end
                end
            end

            assign I00_out[gi]   = pix_q[gi][C00];
            assign I10_out[gi]   = pix_q[gi][C10];
            assign I01_out[gi]   = pix_q[gi][C01];
            assign I11_out[gi]   = pix_q[gi][C11];
            assign alpha_out[gi] = alpha_q[gi];
            assign beta_out[gi]  = beta_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_simd_operand_fetch.sv
// Directed bench for simd_operand_fetch on an 8x8 image; memory returns addr[7:0] one cycle after a read.
module tb_simd_operand_fetch;

    logic              clk;
    logic              rst;
    logic [8:0]        img_w;
    logic [8:0]        img_h;
    logic              req_valid;
    logic              req_ready;
    logic [3:0][15:0]  req_x;
    logic [3:0][15:0]  req_y;
    logic              mem_rd;
    logic [15:0]       mem_addr;
    logic [7:0]        mem_data = 8'd0;
    logic              simd_ready;
    logic              load;
    logic [3:0][7:0]   I00_out;
    logic [3:0][7:0]   I10_out;
    logic [3:0][7:0]   I01_out;
    logic [3:0][7:0]   I11_out;
    logic [3:0][7:0]   alpha_out;
    logic [3:0][7:0]   beta_out;
    logic              busy;

    int tests_run = 0;
    int fail_cnt  = 0;

    logic [15:0] vx [3][4];
    logic [15:0] vy [3][4];
    logic [7:0]  ep [3][4][4];
    logic [7:0]  ea [3][4];
    logic [7:0]  eb [3][4];

    simd_operand_fetch #(
        .N          (4),
        .ADDR_W     (16),
        .FRAC_W     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .img_w      (img_w),
        .img_h      (img_h),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .simd_ready (simd_ready),
        .load       (load),
        .I00_out    (I00_out),
        .I10_out    (I10_out),
        .I01_out    (I01_out),
        .I11_out    (I11_out),
        .alpha_out  (alpha_out),
        .beta_out   (beta_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= mem_addr[7:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string name, input int s);
        for (int l = 0; l < 4; l++) begin
            check($sformatf("%s.I00[%0d]", name, l), I00_out[l], ep[s][l][0]);
            check($sformatf("%s.I10[%0d]", name, l), I10_out[l], ep[s][l][1]);
            check($sformatf("%s.I01[%0d]", name, l), I01_out[l], ep[s][l][2]);
            check($sformatf("%s.I11[%0d]", name, l), I11_out[l], ep[s][l][3]);
            check($sformatf("%s.alpha[%0d]", name, l), alpha_out[l], ea[s][l]);
            check($sformatf("%s.beta[%0d]", name, l), beta_out[l], eb[s][l]);
        end
    endtask

    // Starts and ends at negedge+1; cycle 0 is the accept cycle, cycle k is sampled mid-period.
    task automatic run_txn(input int s, input int bp, input int next_s, input string name);
        int wait_n;
        int load_k;
        int load_cnt;
        int rd_first;
        int rd_last;
        int rd_cnt;
        wait_n   = 0;
        load_k   = -1;
        load_cnt = 0;
        rd_first = -1;
        rd_last  = -1;
        rd_cnt   = 0;
        for (int l = 0; l < 4; l++) begin
            req_x[l] = vx[s][l];
            req_y[l] = vy[s][l];
        end
        req_valid  = 1'b1;
        simd_ready = (bp == 0);
        while (!req_ready && wait_n < 50) begin
            @(negedge clk);
            #1;
            wait_n++;
        end
        check({name, ".accept_wait"}, wait_n, 0);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1 && next_s < 0) req_valid = 1'b0;
            simd_ready = (k >= 18 + bp);
            #1;
            if (mem_rd) begin
                if (rd_first < 0) rd_first = k;
                rd_last = k;
                rd_cnt++;
            end
            if (load) begin
                load_cnt++;
                if (load_k < 0) load_k = k;
            end
            if (bp > 0 && k == 18 + bp/2) begin
                check({name, ".stall_load"}, load, 0);
                check({name, ".stall_ready"}, req_ready, 0);
                check({name, ".stall_busy"}, busy, 1);
                check({name, ".stall_I00"}, I00_out[0], ep[s][0][0]);
                check({name, ".stall_I11"}, I11_out[3], ep[s][3][3]);
            end
            if (load_k == k) begin
                check_outputs(name, s);
                if (next_s >= 0) begin
                    for (int l = 0; l < 4; l++) begin
                        req_x[l] = vx[next_s][l];
                        req_y[l] = vy[next_s][l];
                    end
                    req_valid = 1'b1;
                end
            end
            if (load_k >= 0 && k == load_k + 1) begin
                check({name, ".load_one_cycle"}, load, 0);
                check({name, ".idle_busy"}, busy, 0);
                check({name, ".idle_ready"}, req_ready, 1);
                break;
            end
        end
        if (load_k < 0) check({name, ".load_timeout"}, 0, 1);
        check({name, ".rd_first"}, rd_first, 1);
        check({name, ".rd_last"}, rd_last, 16);
        check({name, ".rd_count"}, rd_cnt, 16);
        check({name, ".load_cycle"}, load_k, 18 + bp);
        check({name, ".load_count"}, load_cnt, 1);
        $display("[TB] txn %s: wait %0d, reads %0d (cycles %0d..%0d), load at cycle %0d",
                 name, wait_n, rd_cnt, rd_first, rd_last, load_k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vx[0] = '{16'h0180, 16'h0310, 16'h0000, 16'h0601};
        vy[0] = '{16'h0240, 16'h0000, 16'h05FF, 16'h0602};
        ep[0] = '{'{8'd17, 8'd18, 8'd25, 8'd26}, '{8'd3, 8'd4, 8'd11, 8'd12},
                  '{8'd40, 8'd41, 8'd48, 8'd49}, '{8'd54, 8'd55, 8'd62, 8'd63}};
        ea[0] = '{8'h80, 8'h10, 8'h00, 8'h01};
        eb[0] = '{8'h40, 8'h00, 8'hFF, 8'h02};

        vx[1] = '{16'h0780, 16'h0200, 16'h0055, 16'h06AA};
        vy[1] = '{16'h0700, 16'h0300, 16'h0133, 16'h06BB};
`ifdef SIMD_FETCH_CLAMP_EN
        ep[1][0] = '{8'd63, 8'd63, 8'd63, 8'd63};
`else
        ep[1][0] = '{8'd63, 8'd64, 8'd71, 8'd72};
`endif
        ep[1][1] = '{8'd26, 8'd27, 8'd34, 8'd35};
        ep[1][2] = '{8'd8, 8'd9, 8'd16, 8'd17};
        ep[1][3] = '{8'd54, 8'd55, 8'd62, 8'd63};
        ea[1] = '{8'h80, 8'h00, 8'h55, 8'hAA};
        eb[1] = '{8'h00, 8'h00, 8'h33, 8'hBB};

        vx[2] = '{16'h0101, 16'h0404, 16'h0520, 16'h0000};
        vy[2] = '{16'h0101, 16'h0404, 16'h0230, 16'h0000};
        ep[2] = '{'{8'd9, 8'd10, 8'd17, 8'd18}, '{8'd36, 8'd37, 8'd44, 8'd45},
                  '{8'd21, 8'd22, 8'd29, 8'd30}, '{8'd0, 8'd1, 8'd8, 8'd9}};
        ea[2] = '{8'h01, 8'h04, 8'h20, 8'h00};
        eb[2] = '{8'h01, 8'h04, 8'h30, 8'h00};

        rst        = 1'b1;
        req_valid  = 1'b0;
        simd_ready = 1'b0;
        req_x      = '0;
        req_y      = '0;
        img_w      = 9'd8;
        img_h      = 9'd8;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.req_ready", req_ready, 1);
        check("reset.mem_rd", mem_rd, 0);
        check("reset.mem_addr", mem_addr, 0);
        check("reset.load", load, 0);
        check("reset.busy", busy, 0);
        check("reset.I00", I00_out, 0);
        check("reset.alpha", alpha_out, 0);
        $display("[TB] txn reset: outputs sampled after power-on reset");

        run_txn(0, 0, -1, "basic");
        run_txn(1, 10, -1, "clamp_bp");

        for (int l = 0; l < 4; l++) begin
            req_x[l] = vx[2][l];
            req_y[l] = vy[2][l];
        end
        req_valid = 1'b1;
        check("rst_mid.ready_pre", req_ready, 1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            #1;
            if (k == 1) req_valid = 1'b0;
        end
        check("rst_mid.rd_cycle5", mem_rd, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid.mem_rd", mem_rd, 0);
        check("rst_mid.req_ready", req_ready, 1);
        check("rst_mid.busy", busy, 0);
        check("rst_mid.load", load, 0);
        check("rst_mid.I00_l0", I00_out[0], 0);
        check("rst_mid.I11_l3", I11_out[3], 0);
        check("rst_mid.alpha_l0", alpha_out[0], 0);
        $display("[TB] txn rst_mid: reset asserted in cycle 5 of issue");

        run_txn(2, 0, -1, "after_rst");
        run_txn(0, 0, 2, "b2b_first");
        run_txn(2, 0, -1, "b2b_second");

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
